// File: rtl/dbg_pkg.sv
// Shared types and defaults for the data-memory debug arbiter.
package dbg_pkg;

   localparam int XLEN_DEF         = 32;
   localparam int STARVE_LIMIT_DEF = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } dbg_arb_state_t;

   // A limit of 0 still needs a 1-bit counter.
   function automatic int cnt_width(input int limit);
      return (limit > 0) ? $clog2(limit + 1) : 1;
   endfunction

endpackage

// File: rtl/dmem_dbg_arbiter_if.sv
// Four-phase debug access channel into the data-memory arbiter.
interface dmem_dbg_arbiter_if
   import dbg_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) ();

   logic            dbg_req;
   logic            dbg_we;
   logic [XLEN-1:0] dbg_adr;
   logic [XLEN-1:0] dbg_wdata;
   logic            dbg_ack;
   logic [XLEN-1:0] dbg_rdata;
   logic            dbg_err;

   modport master (
      output dbg_req, dbg_we, dbg_adr, dbg_wdata,
      input  dbg_ack, dbg_rdata, dbg_err
   );

   modport slave (
      input  dbg_req, dbg_we, dbg_adr, dbg_wdata,
      output dbg_ack, dbg_rdata, dbg_err
   );

endinterface

// File: rtl/dbg_starve_ctr.sv
// Saturating count of cycles a debug request has been blocked by CPU traffic.
module dbg_starve_ctr
   import dbg_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic sysclk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic at_limit
);

   localparam int CNT_W = cnt_width(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_dbg_arbiter.sv
// Shares the data-memory port between the M stage and the debug channel.
// Debug writes are only performed when DBG_MEM_WRITE_EN is defined.
module dmem_dbg_arbiter
   import dbg_pkg::*;
#(
   parameter int XLEN         = XLEN_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                 sysclk,
   input  logic                 reset,
   input  logic                 cpu_mem_en,
   input  logic                 cpu_we,
   input  logic [XLEN-1:0]      cpu_adr,
   input  logic [XLEN-1:0]      cpu_wdata,
   output logic [XLEN-1:0]      cpu_rdata,
   output logic                 cpu_stall,
   dmem_dbg_arbiter_if.slave    dbg,
   output logic                 mem_we,
   output logic [XLEN-1:0]      mem_adr,
   output logic [XLEN-1:0]      mem_wdata,
   input  logic [XLEN-1:0]      mem_rdata
);

   dbg_arb_state_t  state_q, state_d;
   logic            err_q, err_d;
   logic            stall_q, stall_d;
   logic            ack_q, ack_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            at_limit;
   logic            grant;
   logic            reject;
   logic            cnt_en;
   logic            in_access;

   assign grant  = (state_q == IDLE) && dbg.dbg_req && (!cpu_mem_en || at_limit);
   assign cnt_en = (state_q == IDLE) && dbg.dbg_req && cpu_mem_en && !grant;

`ifdef DBG_MEM_WRITE_EN
   assign reject = (dbg.dbg_adr[1:0] != 2'b00);
`else
   assign reject = (dbg.dbg_adr[1:0] != 2'b00) || dbg.dbg_we;
`endif

   dbg_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_ctr (
      .sysclk   (sysclk),
      .reset    (reset),
      .en       (cnt_en),
      .clr      (grant),
      .at_limit (at_limit)
   );

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               if (reject) begin
                  state_d = RESP;
                  err_d   = 1'b1;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            // Unconditional capture: a write returns the word it overwrote.
            rdata_d = mem_rdata;
            state_d = RESP;
         end
         RESP: begin
            if (!dbg.dbg_req) begin
               state_d = IDLE;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      // Handshake outputs come straight from flops so they cannot glitch.
      stall_d = (state_d == ACCESS);
      ack_d   = (state_d == RESP);
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
         stall_q <= 1'b0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         stall_q <= stall_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   assign in_access = stall_q;

   always_comb begin
      mem_adr   = in_access ? dbg.dbg_adr   : cpu_adr;
      mem_wdata = in_access ? dbg.dbg_wdata : cpu_wdata;
`ifdef DBG_MEM_WRITE_EN
      mem_we    = in_access ? dbg.dbg_we    : (cpu_we & cpu_mem_en);
`else
      mem_we    = in_access ? 1'b0          : (cpu_we & cpu_mem_en);
`endif
   end

   assign cpu_rdata     = mem_rdata;
   assign cpu_stall     = stall_q;
   assign dbg.dbg_ack   = ack_q;
   assign dbg.dbg_err   = err_q;
   assign dbg.dbg_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_dbg_arbiter.sv
// Directed bench for dmem_dbg_arbiter with a small word-addressed memory model.
module tb_dmem_dbg_arbiter;

   localparam int XLEN = 32;

   logic            sysclk = 1'b0;
   logic            reset;
   logic            cpu_mem_en;
   logic            cpu_we;
   logic [XLEN-1:0] cpu_adr;
   logic [XLEN-1:0] cpu_wdata;
   logic [XLEN-1:0] cpu_rdata;
   logic            cpu_stall;
   logic            mem_we;
   logic [XLEN-1:0] mem_adr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata;

   logic [31:0] mem [0:63];

   int checks = 0;
   int errors = 0;

   always #5 sysclk = ~sysclk;

   dmem_dbg_arbiter_if #(.XLEN(XLEN)) dbg_if ();

   dmem_dbg_arbiter #(
      .XLEN         (XLEN),
      .STARVE_LIMIT (4)
   ) dut (
      .sysclk     (sysclk),
      .reset      (reset),
      .cpu_mem_en (cpu_mem_en),
      .cpu_we     (cpu_we),
      .cpu_adr    (cpu_adr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .dbg        (dbg_if),
      .mem_we     (mem_we),
      .mem_adr    (mem_adr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   assign mem_rdata = mem[mem_adr[7:2]];

   always @(posedge sysclk) begin
      if (mem_we) mem[mem_adr[7:2]] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge sysclk);
      #1;
   endtask

   task automatic dbg_drive(input logic req, input logic we, input logic [31:0] adr,
                            input logic [31:0] wdata);
      dbg_if.dbg_req   = req;
      dbg_if.dbg_we    = we;
      dbg_if.dbg_adr   = adr;
      dbg_if.dbg_wdata = wdata;
   endtask

   task automatic cpu_drive(input logic en, input logic we, input logic [31:0] adr,
                            input logic [31:0] wdata);
      cpu_mem_en = en;
      cpu_we     = we;
      cpu_adr    = adr;
      cpu_wdata  = wdata;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[24] = 32'd25;
      mem[25] = 32'd11;
      mem[26] = 32'h33;
      reset = 1'b1;
      cpu_drive(1'b0, 1'b1, 32'h10, 32'hAB);
      dbg_drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick;
      tick;

      // Reset state: memory port follows the CPU
      check("rst_stall", {31'd0, cpu_stall}, 32'd0);
      check("rst_ack", {31'd0, dbg_if.dbg_ack}, 32'd0);
      check("rst_err", {31'd0, dbg_if.dbg_err}, 32'd0);
      check("rst_rdata", dbg_if.dbg_rdata, 32'd0);
      check("rst_memadr", mem_adr, 32'h10);
      check("rst_memwd", mem_wdata, 32'hAB);
      check("rst_memwe", {31'd0, mem_we}, 32'd0);
      reset = 1'b0;
      cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);

      // Debug read of 0x60 with idle CPU
      tick;
      dbg_drive(1'b1, 1'b0, 32'h60, 32'h0);
      tick;
      check("rd_stall", {31'd0, cpu_stall}, 32'd1);
      check("rd_ack_early", {31'd0, dbg_if.dbg_ack}, 32'd0);
      check("rd_memadr", mem_adr, 32'h60);
      check("rd_memwe", {31'd0, mem_we}, 32'd0);
      tick;
      check("rd_stall_end", {31'd0, cpu_stall}, 32'd0);
      check("rd_ack", {31'd0, dbg_if.dbg_ack}, 32'd1);
      check("rd_data", dbg_if.dbg_rdata, 32'd25);
      check("rd_err", {31'd0, dbg_if.dbg_err}, 32'd0);
      tick;
      check("rd_ack_hold", {31'd0, dbg_if.dbg_ack}, 32'd1);
      dbg_if.dbg_req = 1'b0;
      tick;
      check("rd_ack_fall", {31'd0, dbg_if.dbg_ack}, 32'd0);

      // Debug write of 7 to 0x64, then CPU load
      dbg_drive(1'b1, 1'b1, 32'h64, 32'd7);
      tick;
`ifdef DBG_MEM_WRITE_EN
      check("wr_stall", {31'd0, cpu_stall}, 32'd1);
      check("wr_memwe", {31'd0, mem_we}, 32'd1);
      tick;
      check("wr_ack", {31'd0, dbg_if.dbg_ack}, 32'd1);
      check("wr_err", {31'd0, dbg_if.dbg_err}, 32'd0);
      check("wr_oldword", dbg_if.dbg_rdata, 32'd11);
`else
      check("wr_stall", {31'd0, cpu_stall}, 32'd0);
      check("wr_ack", {31'd0, dbg_if.dbg_ack}, 32'd1);
      check("wr_err", {31'd0, dbg_if.dbg_err}, 32'd1);
      check("wr_memwe", {31'd0, mem_we}, 32'd0);
`endif
      dbg_if.dbg_req = 1'b0;
      tick;
      check("wr_ack_fall", {31'd0, dbg_if.dbg_ack}, 32'd0);
      check("wr_err_clr", {31'd0, dbg_if.dbg_err}, 32'd0);
      cpu_drive(1'b1, 1'b0, 32'h64, 32'h0);
      #1;
`ifdef DBG_MEM_WRITE_EN
      check("wr_cpu_load", cpu_rdata, 32'd7);
`else
      check("wr_cpu_load", cpu_rdata, 32'd11);
`endif

      // Starvation: CPU busy every cycle, grant after 4 blocked cycles
      cpu_drive(1'b1, 1'b0, 32'h0, 32'h0);
      dbg_drive(1'b1, 1'b0, 32'h68, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick;
         check($sformatf("starve_blk%0d", i), {31'd0, cpu_stall}, 32'd0);
      end
      tick;
      check("starve_grant", {31'd0, cpu_stall}, 32'd1);
      cpu_drive(1'b1, 1'b1, 32'h68, 32'h55);
      #1;
      check("starve_st_blk", {31'd0, mem_we}, 32'd0);
      check("starve_memadr", mem_adr, 32'h68);
      tick;
      check("starve_ack", {31'd0, dbg_if.dbg_ack}, 32'd1);
      check("starve_rdata", dbg_if.dbg_rdata, 32'h33);
      check("starve_retry", {31'd0, mem_we}, 32'd1);
      dbg_if.dbg_req = 1'b0;
      tick;
      cpu_drive(1'b1, 1'b0, 32'h68, 32'h0);
      #1;
      check("starve_landed", cpu_rdata, 32'h55);
      cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);

      // Misaligned access is rejected without stall or memory write
      dbg_drive(1'b1, 1'b1, 32'h62, 32'hDEAD);
      tick;
      check("mis_stall", {31'd0, cpu_stall}, 32'd0);
      check("mis_ack", {31'd0, dbg_if.dbg_ack}, 32'd1);
      check("mis_err", {31'd0, dbg_if.dbg_err}, 32'd1);
      check("mis_memwe", {31'd0, mem_we}, 32'd0);
      dbg_if.dbg_req = 1'b0;
      tick;
      check("mis_ack_fall", {31'd0, dbg_if.dbg_ack}, 32'd0);

      // Reset asserted mid-ACCESS
      dbg_drive(1'b1, 1'b0, 32'h60, 32'h0);
      tick;
      check("ra_stall_pre", {31'd0, cpu_stall}, 32'd1);
      #2;
      reset = 1'b1;
      cpu_adr = 32'h10;
      #1;
      check("ra_stall", {31'd0, cpu_stall}, 32'd0);
      check("ra_ack", {31'd0, dbg_if.dbg_ack}, 32'd0);
      check("ra_memadr", mem_adr, 32'h10);
      dbg_if.dbg_req = 1'b0;
      cpu_adr = 32'h0;
      reset = 1'b0;

      // Counter cleared asynchronously by reset
      tick;
      cpu_drive(1'b1, 1'b0, 32'h0, 32'h0);
      dbg_drive(1'b1, 1'b0, 32'h60, 32'h0);
      tick;
      tick;
      check("cnt_two", 32'(dut.u_ctr.cnt_q), 32'd2);
      #1;
      reset = 1'b1;
      #1;
      check("cnt_rst", 32'(dut.u_ctr.cnt_q), 32'd0);
      dbg_if.dbg_req = 1'b0;
      cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b0;

      // Next request after reset completes normally
      tick;
      dbg_drive(1'b1, 1'b0, 32'h60, 32'h0);
      tick;
      check("post_stall", {31'd0, cpu_stall}, 32'd1);
      tick;
      check("post_ack", {31'd0, dbg_if.dbg_ack}, 32'd1);
      check("post_rdata", dbg_if.dbg_rdata, 32'd25);
      dbg_if.dbg_req = 1'b0;
      tick;

      // Back-to-back requests around a stalled CPU store of 25 to 100
      dbg_drive(1'b1, 1'b0, 32'h60, 32'h0);
      tick;
      check("b2b_stall1", {31'd0, cpu_stall}, 32'd1);
      cpu_drive(1'b1, 1'b1, 32'h64, 32'd25);
      #1;
      check("b2b_st_blk", {31'd0, mem_we}, 32'd0);
      tick;
      check("b2b_ack1", {31'd0, dbg_if.dbg_ack}, 32'd1);
      check("b2b_st_go", {31'd0, mem_we}, 32'd1);
      check("b2b_st_adr", mem_adr, 32'h64);
      dbg_if.dbg_req = 1'b0;
      tick;
      check("b2b_ack1_fall", {31'd0, dbg_if.dbg_ack}, 32'd0);
      cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
      dbg_drive(1'b1, 1'b0, 32'h64, 32'h0);
      tick;
      check("b2b_stall2", {31'd0, cpu_stall}, 32'd1);
      tick;
      check("b2b_stall2_end", {31'd0, cpu_stall}, 32'd0);
      check("b2b_ack2", {31'd0, dbg_if.dbg_ack}, 32'd1);
      check("b2b_rdata2", dbg_if.dbg_rdata, 32'd25);
      dbg_if.dbg_req = 1'b0;
      tick;
      check("b2b_ack2_fall", {31'd0, dbg_if.dbg_ack}, 32'd0);
      cpu_drive(1'b1, 1'b0, 32'h64, 32'h0);
      #1;
      check("b2b_cpu_load", cpu_rdata, 32'd25);
      cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_dbg_arbiter.md
# dmem_dbg_arbiter

- Shares the single data-memory port between the RISC-V pipeline's memory stage and the JTAG debug access path.
- The CPU owns the port by default. A debug read or write is granted when the CPU has no memory operation in M, or after a bounded starvation wait.
- While the debug access runs, the pipeline is stalled for one cycle.
- The block sits in `top` between the pipeline's M-stage memory signals and `dmem`, all in the `sysclk` domain. Debug requests arrive already synchronized from the `tck` domain.

## Interface
Parameters:
- `XLEN`, 32: data and address width.
- `STARVE_LIMIT`, 4: number of blocked request cycles before debug is forced in. 0 grants debug immediately.

Ports:
- `sysclk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_mem_en`  in  1  memory operation present in M stage.
- `cpu_we`  in  1  CPU store (MemWriteM).
- `cpu_adr`  in  XLEN  CPU address (DataAdrM).
- `cpu_wdata`  in  XLEN  CPU store data (WriteDataM).
- `cpu_rdata`  out  XLEN  CPU load data; equals `mem_rdata`.
- `cpu_stall`  out  1  freezes the pipeline.
- `dbg_req`  in  1  four-phase request.
- `dbg_we`  in  1  debug write.
- `dbg_adr`  in  XLEN  debug address.
- `dbg_wdata`  in  XLEN  debug write data.
- `dbg_ack`  out  1  four-phase acknowledge.
- `dbg_rdata`  out  XLEN  registered debug read data; valid while `dbg_ack` is high.
- `dbg_err`  out  1  access rejected; valid while `dbg_ack` is high.
- `mem_we`  out  1  memory write enable.
- `mem_adr`  out  XLEN  memory address.
- `mem_wdata`  out  XLEN  memory write data.
- `mem_rdata`  in  XLEN  combinational memory read data.

## Operation
States: IDLE, ACCESS, RESP.

- **IDLE**
  - The memory port passes the CPU signals through. `mem_we` = `cpu_we & cpu_mem_en`.
  - Grant condition: `dbg_req & (!cpu_mem_en | starve_cnt == STARVE_LIMIT)`.
  - On grant with `dbg_adr[1:0] == 0`, go to ACCESS.
  - On grant with `dbg_adr[1:0] != 0`, go to RESP with `dbg_err` = 1. No memory access and no stall.
- **ACCESS**
  - `cpu_stall` = 1.
  - `mem_adr` = `dbg_adr`, `mem_wdata` = `dbg_wdata`, `mem_we` = `dbg_we`.
  - `dbg_rdata` <= `mem_rdata`; capture is unconditional, so writes capture the old word.
  - Go to RESP.
- **RESP**
  - The memory port returns to the CPU and `cpu_stall` = 0.
  - `dbg_ack` = 1.
  - Stay in RESP while `dbg_req` is high. When `dbg_req` is low, go to IDLE and clear `dbg_err`.

Starvation counter:
- Increments in IDLE when `dbg_req & cpu_mem_en` and no grant occurs.
- Saturates at `STARVE_LIMIT` and clears on grant.
- Width is `$clog2(STARVE_LIMIT+1)`, minimum 1 bit.

Master rules:
- `dbg_adr`, `dbg_we` and `dbg_wdata` must stay stable from `dbg_req` rise until `dbg_ack` rises.
- Request signals are sampled only in IDLE and ACCESS.

## Timing
- Reset values: state IDLE; `cpu_stall`, `dbg_ack` and `dbg_err` at 0; `dbg_rdata` at 0; counter at 0. Memory outputs follow the CPU inputs.
- A grant decided in cycle N gives ACCESS in N+1 and `dbg_ack` in N+2.
- A rejected (misaligned) request gives `dbg_ack` in N+1.
- The CPU loses exactly one cycle per accepted debug access.
- `cpu_stall`, `dbg_ack` and `dbg_err` are decoded from registered state only and are glitch-free.
- `dbg_req` falling in cycle M (while in RESP) gives IDLE in M+1. A new request can be granted in M+1 at the earliest.
- Reset asserted mid-ACCESS: outputs return to reset values immediately and asynchronously. A write in progress may or may not have committed.
- `dbg_req` dropped before ack violates the protocol. The arbiter still completes the access and then returns to IDLE from RESP.

## Configuration
- `DBG_MEM_WRITE_EN` defined: debug writes are performed as described above.
- `DBG_MEM_WRITE_EN` undefined:
  - `dbg_we` is ignored, and `mem_we` is never asserted in ACCESS.
  - A request with `dbg_we` = 1 is rejected like a misaligned one: it takes the RESP path with `dbg_err` = 1 and no stall.
  - Reads are unchanged.

## Structure
- Shared package `dbg_pkg`:
  - state enum `dbg_arb_state_t`;
  - default `XLEN` and `STARVE_LIMIT` constants.
- Natural sub-module: `dbg_starve_ctr`, the saturating counter with enable, clear and at-limit flag.
- FSM, muxing and read-data register stay in `dmem_dbg_arbiter`.

## Test plan
- Idle CPU (`cpu_mem_en` = 0), debug read of 0x60 holding 25 → `cpu_stall` high for 1 cycle, `dbg_ack` two cycles after `dbg_req`, `dbg_rdata` = 25; ack falls one cycle after `dbg_req` falls.
- Debug write of 7 to 0x64, then CPU load of 0x64 → CPU reads 7. With `DBG_MEM_WRITE_EN` undefined → `dbg_err` = 1, no stall, CPU load returns the old value.
- `cpu_mem_en` held at 1 with `STARVE_LIMIT` = 4 and `dbg_req` raised → grant after exactly 4 blocked cycles; the CPU store in the ACCESS cycle is stalled and retried, and lands after the debug access.
- Debug access to 0x62 → `dbg_err` = 1 and `dbg_ack` one cycle after grant; `mem_we` never comes from debug and there is no stall.
- Reset asserted during ACCESS → `cpu_stall`, `dbg_ack` and the counter are 0 without waiting for a clock edge; the next request completes normally.
- Back-to-back requests (new `dbg_req` one cycle after ack falls) → each completes with one stall cycle, and CPU stores to 100 = 25 still commit in order.
